rule30_stream_ctrl: RTL
=======================

# rule30_stream_ctrl

Sequencing controller for the Rule 30 XOR stream cipher path. It holds the 8-bit Rule 30 key register and loads it from a seed. It optionally discards warm-up generations, then steps the key once per accepted data byte, XORing each byte with the freshly stepped key. It sits between a byte source and a byte sink using valid/ready handshakes. Encryption and decryption are the same operation: the same seed yields the same keystream.

## Interface
- WARMUP, default 0: Rule 30 generations discarded after every (re)seed, range 0..255.
- REKEY_INTERVAL, default 0: bytes per key epoch. 0 means never rekey. N>0 means reload the stored seed (plus warm-up) after every N accepted bytes.
- DEFAULT_SEED, default 8'h18: substituted whenever a seed of 8'h00 is loaded.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- seed_load  input  1  single-cycle command to load `seed`.
- seed  input  8  seed value, sampled when seed_load=1.
- in_valid  input  1  source has a byte.
- in_ready  output  1  controller accepts a byte this cycle.
- in_data  input  8  plaintext or ciphertext byte.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  sink accepts out_data.
- out_data  output  8  in_data XOR keystream byte.
- busy  output  1  warm-up in progress.
- key_out  output  8  current key register K.
- byte_count  output  16  bytes accepted since last seed_load; saturates at 16'hFFFF.

## Operation
- Step function: R(K)[i] = K[i-1] ^ (K[i] | K[i+1]), indices mod 8. This is Rule 30, table 8'b00011110, indexed by {left, centre, right}.
- Stored seed S: written on seed_load; S = (seed==0) ? DEFAULT_SEED : seed.
- State IDLE (after reset):
  - in_ready=0.
  - Only seed_load has an effect.
- seed_load, in any state:
  - K<=S.
  - out_valid<=0; a pending output byte is discarded.
  - byte_count<=0; epoch counter<=0; warm counter<=0.
  - Next state is WARM if WARMUP>0, else RUN.
- State WARM:
  - K<=R(K) each cycle; warm counter increments.
  - After WARMUP steps, go to RUN.
  - busy=1, in_ready=0.
- State RUN:
  - in_ready = !seed_load && (!out_valid || out_ready).
  - On handshake (in_valid && in_ready): K<=R(K); out_data<=in_data ^ R(K); out_valid<=1; byte_count incremented (saturating); epoch counter incremented.
  - If out_valid && out_ready with no new beat, out_valid<=0.
- Rekey: REKEY_INTERVAL=N>0 and the N-th byte of an epoch is accepted.
  - That byte completes normally.
  - Then K<=S, epoch counter<=0, and go to WARM (or stay in RUN if WARMUP=0).
  - byte_count is not cleared.
  - The pending output stays valid and drains normally.
- Priority: rst > seed_load > rekey > data beat.

## Timing
- Reset values:
  - state IDLE.
  - K=8'h00; S=DEFAULT_SEED.
  - out_valid=0, out_data=8'h00.
  - in_ready=0, busy=0.
  - key_out=8'h00, byte_count=0.
- seed_load in cycle t:
  - K=S visible on key_out at t+1.
  - WARMUP=0: in_ready can be high at t+1.
  - Otherwise busy=1 for cycles t+1..t+WARMUP, and in_ready can be high at t+WARMUP+1.
- Data latency: a byte accepted at edge t appears with out_valid=1 after that edge, i.e. in cycle t+1.
- Throughput: one byte per cycle while out_ready=1.
- Output stall: out_valid=1 && out_ready=0 forces in_ready=0. out_data and K are held.
- Rekey at epoch end inserts exactly WARMUP bubble cycles. No bubble when WARMUP=0.
- Mid-warm-up seed_load restarts warm-up from the new seed.
- rst asserted mid-stream clears outputs immediately (asynchronously). It does not wait for a clock edge.

## Test plan
- Keystream, WARMUP=0:
  - Stimulus: reset, seed_load seed=8'h18, then stream in_data=00,00,00 with out_ready=1.
  - Response: out_data=2C,66,BB on consecutive cycles; key_out=BB; byte_count=3.
- Round trip: encrypt 8'h41,8'h42 with seed 8'h18, reseed with 8'h18, feed the ciphertext back.
  - Encrypt response: 6D,24.
  - Decrypt response: 41,42.
- Warm-up, WARMUP=2:
  - Stimulus: seed_load 8'h18, then in_data=00.
  - Response: busy high for 2 cycles, in_ready low during warm-up, first out_data=BB.
- Backpressure: hold out_ready=0 for 3 cycles while in_valid=1.
  - Response: in_ready=0; out_data and key_out stable; no byte lost or duplicated when out_ready returns.
- Rekey and zero seed: REKEY_INTERVAL=2, seed_load 8'h00.
  - Stimulus: 4 zero bytes.
  - Response: out_data=2C,66,2C,66; byte_count=4.
- Reseed mid-stream: seed_load asserted while out_valid=1 and out_ready=0.
  - Response: out_valid drops next cycle; in_ready=0 in the seed_load cycle; byte_count=0.
- Async reset: assert rst between clock edges during streaming.
  - Response: all outputs take their reset values without a clock edge.

Source files
------------

// File: rtl/rule30_stream_ctrl.sv
// Rule 30 keystream sequencer: seeds/warms the 8-bit key register and XORs
// each accepted byte with the freshly stepped key between valid/ready ports.
module rule30_stream_ctrl #(
  parameter int unsigned WARMUP         = 0,
  parameter int unsigned REKEY_INTERVAL = 0,
  parameter logic [7:0]  DEFAULT_SEED   = 8'h18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_load,
  input  logic [7:0]  seed,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        busy,
  output logic [7:0]  key_out,
  output logic [15:0] byte_count
);

  typedef enum logic [1:0] {
    IDLE,
    WARM,
    RUN
  } state_t;

  localparam bit          WARM_EN    = (WARMUP != 0);
  localparam bit          REKEY_EN   = (REKEY_INTERVAL != 0);
  localparam logic [8:0]  WARM_LAST  = 9'((WARMUP == 0) ? 0 : WARMUP - 1);
  localparam logic [31:0] EPOCH_LAST = 32'((REKEY_INTERVAL == 0) ? 0 : REKEY_INTERVAL - 1);

  // Rule 30 on a ring: new[i] = K[i-1] ^ (K[i] | K[i+1])
  function automatic logic [7:0] rule30_step(input logic [7:0] k);
    logic [7:0] left_n;
    logic [7:0] right_n;
    left_n  = {k[6:0], k[7]};
    right_n = {k[0], k[7:1]};
    return left_n ^ (k | right_n);
  endfunction

  state_t      state;
  state_t      state_nx;
  logic [7:0]  key_q;
  logic [7:0]  seed_q;
  logic [7:0]  out_data_q;
  logic        out_valid_q;
  logic [15:0] byte_cnt_q;
  logic [31:0] epoch_cnt_q;
  logic [8:0]  warm_cnt_q;

  logic [7:0]  seed_eff;
  logic [7:0]  key_step;
  logic        beat;
  logic        rekey;
  logic        warm_done;

  assign seed_eff  = (seed == '0) ? DEFAULT_SEED : seed;
  assign key_step  = rule30_step(key_q);
  assign beat      = in_valid && in_ready;
  assign rekey     = REKEY_EN && beat && (epoch_cnt_q == EPOCH_LAST);
  assign warm_done = (warm_cnt_q == WARM_LAST);

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign key_out    = key_q;
  assign byte_count = byte_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (seed_load) begin
      state_nx = WARM_EN ? WARM : RUN;
    end else begin
      case (state)
        IDLE:    state_nx = IDLE;
        WARM:    if (warm_done) state_nx = RUN;
        RUN:     if (rekey && WARM_EN) state_nx = WARM;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      WARM:    busy = 1'b1;
      RUN:     in_ready = !seed_load && (!out_valid_q || out_ready);
      default: ;
    endcase
  end

  // A rekey overrides the beat's key step; the beat's output byte still
  // uses the stepped key so the epoch's last byte completes normally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q       <= '0;
      seed_q      <= DEFAULT_SEED;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      byte_cnt_q  <= '0;
      epoch_cnt_q <= '0;
      warm_cnt_q  <= '0;
    end else if (seed_load) begin
      seed_q      <= seed_eff;
      key_q       <= seed_eff;
      out_valid_q <= 1'b0;
      byte_cnt_q  <= '0;
      epoch_cnt_q <= '0;
      warm_cnt_q  <= '0;
    end else begin
      if (state == WARM) begin
        key_q      <= key_step;
        warm_cnt_q <= warm_cnt_q + 9'd1;
      end
      if (beat) begin
        out_data_q  <= in_data ^ key_step;
        out_valid_q <= 1'b1;
        if (byte_cnt_q != '1) begin
          byte_cnt_q <= byte_cnt_q + 16'd1;
        end
        if (rekey) begin
          key_q       <= seed_q;
          epoch_cnt_q <= '0;
          warm_cnt_q  <= '0;
        end else begin
          key_q       <= key_step;
          epoch_cnt_q <= epoch_cnt_q + 32'd1;
        end
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
